feature_add_pair_feeder: RTL

//  Source-side counterpart of the feature-add stage: accepts two independent 8-lane feature streams
//  (x1 = main path, x2 = shortcut path) arriving with differing latency, buffers/aligns them, and

---
 rtl/feature_add_pair_feeder_pkg.sv | 25 ++
 rtl/feature_add_pair_feeder_fifo.sv | 61 ++++++
 rtl/feature_add_pair_feeder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/feature_add_pair_feeder_pkg.sv
// Shared definitions for the feature-add pair feeder.
//  - Default feature lane width.
//  - Lane count per beat.
//  - FSM state type.
//  - Saturating absolute-difference helper, used by the skew monitor.
package feature_add_pair_feeder_pkg;

  localparam int FEATURE_WIDTH_DEF = 16;

  localparam int LANE_NUM = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feeder_state_e;

  // |a-b| clipped to 8 bits.
  function automatic logic [7:0] sat_abs_diff(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] diff;
    diff = (a > b) ? (a - b) : (b - a);
    return (diff > 16'd255) ? 8'hFF : diff[7:0];
  endfunction

endpackage

// File: rtl/feature_add_pair_feeder_fifo.sv
// feature_pair_fifo: a synchronous, show-ahead FIFO. One instance is used per input side.
//  Ports:
//   system_clk, rst_n : clock and asynchronous active-low reset. Reset clears only the pointers and the count.
//   wr_data, push     : write port. A push is taken when the FIFO is not full, or when a pop happens in the same cycle.
//   rd_data, pop      : rd_data always shows the head entry. pop removes the head.
//   full, empty, count: occupancy status, driven from registered state.
//  The storage array has no reset. Its contents are only read after a write.
module feature_pair_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             system_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    // DEPTH is a power of two, so the pointers wrap naturally.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge system_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/feature_add_pair_feeder.sv
// feature_add_pair_feeder
//  Takes two independent 8-lane feature streams: x1 (main path) and x2 (shortcut path).
//  Each stream is buffered in its own skew FIFO. The module pops the two FIFOs in lock-step and
//  emits the k-th x1 beat paired with the k-th x2 beat under one shared valid strobe.
//  Each accepted start runs one tile of beat_num beats per side.
//  Ports:
//   system_clk, rst_n           : clock and asynchronous active-low reset.
//   start, beat_num             : begin a tile. start is ignored while busy. beat_num is sampled only on an accepted start.
//   x1_data_in/valid_in/ready_out : main-path input handshake.
//   x2_data_in/valid_in/ready_out : shortcut-path input handshake.
//   out_ready_in                : downstream can take a pair this cycle.
//   feature_x1_out/x2_out       : registered paired words. They hold their value between strobes.
//   feature_x_valid_out         : one-cycle strobe per emitted pair.
//   busy, done                  : busy is high from the accepted start until done. done is a one-cycle pulse.
//   skew_max                    : peak |occupancy1-occupancy2|. This output is live only when
//                                 FEATURE_FEEDER_SKEW_MON_EN is defined. Otherwise it is 0.
//  Handshake: a beat moves on a rising edge where valid and ready are both high.
//   ready depends only on registered state and never on valid.
//   A producer must hold its data stable while valid is high and the beat has not been taken.
module feature_add_pair_feeder
  import feature_add_pair_feeder_pkg::*;
#(
  parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF,
  parameter int FIFO_DEPTH    = 8,
  parameter int LEN_WIDTH     = 16,
  localparam int BUS_W        = FEATURE_WIDTH * LANE_NUM
) (
  input  logic                 system_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] beat_num,
  input  logic [BUS_W-1:0]     x1_data_in,
  input  logic                 x1_valid_in,
  output logic                 x1_ready_out,
  input  logic [BUS_W-1:0]     x2_data_in,
  input  logic                 x2_valid_in,
  output logic                 x2_ready_out,
  input  logic                 out_ready_in,
  output logic [BUS_W-1:0]     feature_x1_out,
  output logic [BUS_W-1:0]     feature_x2_out,
  output logic                 feature_x_valid_out,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           skew_max
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  feeder_state_e        state_q, state_d;
  logic [LEN_WIDTH-1:0] beat_num_q, beat_num_d;
  logic [LEN_WIDTH-1:0] in_cnt1_q, in_cnt1_d;
  logic [LEN_WIDTH-1:0] in_cnt2_q, in_cnt2_d;
  logic [LEN_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [BUS_W-1:0]     x1_out_q, x1_out_d;
  logic [BUS_W-1:0]     x2_out_q, x2_out_d;
  logic                 valid_q, valid_d;

  logic [BUS_W-1:0]     fifo1_head, fifo2_head;
  logic                 fifo1_full, fifo1_empty, fifo2_full, fifo2_empty;
  logic [CNT_W-1:0]     fifo1_count, fifo2_count;
  logic                 push1, push2, pop_pair, start_acc;

  assign start_acc    = start & (state_q == ST_IDLE);
  // Each side stops accepting once the tile's beat quota is reached, so extra beats stall.
  assign x1_ready_out = (state_q == ST_RUN) & ~fifo1_full & (in_cnt1_q < beat_num_q);
  assign x2_ready_out = (state_q == ST_RUN) & ~fifo2_full & (in_cnt2_q < beat_num_q);
  assign push1        = x1_valid_in & x1_ready_out;
  assign push2        = x2_valid_in & x2_ready_out;
  assign pop_pair     = (state_q == ST_RUN) & ~fifo1_empty & ~fifo2_empty & out_ready_in;

  feature_pair_fifo #(.WIDTH(BUS_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .wr_data    (x1_data_in),
    .push       (push1),
    .pop        (pop_pair),
    .rd_data    (fifo1_head),
    .full       (fifo1_full),
    .empty      (fifo1_empty),
    .count      (fifo1_count)
  );

  feature_pair_fifo #(.WIDTH(BUS_W), .DEPTH(FIFO_DEPTH)) u_fifo2 (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .wr_data    (x2_data_in),
    .push       (push2),
    .pop        (pop_pair),
    .rd_data    (fifo2_head),
    .full       (fifo2_full),
    .empty      (fifo2_empty),
    .count      (fifo2_count)
  );

  always_comb begin
    state_d    = state_q;
    beat_num_d = beat_num_q;
    in_cnt1_d  = in_cnt1_q;
    in_cnt2_d  = in_cnt2_q;
    out_cnt_d  = out_cnt_q;
    x1_out_d   = x1_out_q;
    x2_out_d   = x2_out_q;
    valid_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          beat_num_d = beat_num;
          in_cnt1_d  = '0;
          in_cnt2_d  = '0;
          out_cnt_d  = '0;
          // An empty tile still produces a busy/done handshake.
          state_d    = (beat_num == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (push1) in_cnt1_d = in_cnt1_q + LEN_WIDTH'(1);
        if (push2) in_cnt2_d = in_cnt2_q + LEN_WIDTH'(1);
        if (pop_pair) begin
          x1_out_d  = fifo1_head;
          x2_out_d  = fifo2_head;
          valid_d   = 1'b1;
          out_cnt_d = out_cnt_q + LEN_WIDTH'(1);
          // The final strobe and done appear in the same cycle.
          if (out_cnt_q == beat_num_q - LEN_WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_num_q <= '0;
      in_cnt1_q  <= '0;
      in_cnt2_q  <= '0;
      out_cnt_q  <= '0;
      x1_out_q   <= '0;
      x2_out_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_num_q <= beat_num_d;
      in_cnt1_q  <= in_cnt1_d;
      in_cnt2_q  <= in_cnt2_d;
      out_cnt_q  <= out_cnt_d;
      x1_out_q   <= x1_out_d;
      x2_out_q   <= x2_out_d;
      valid_q    <= valid_d;
    end
  end

  assign feature_x1_out      = x1_out_q;
  assign feature_x2_out      = x2_out_q;
  assign feature_x_valid_out = valid_q;
  assign busy                = (state_q != ST_IDLE);
  assign done                = (state_q == ST_DONE);

`ifdef FEATURE_FEEDER_SKEW_MON_EN
  logic [7:0] skew_q, skew_d, skew_now;

  always_comb begin
    skew_now = sat_abs_diff(16'(fifo1_count), 16'(fifo2_count));
    skew_d   = skew_q;
    if (start_acc)                                     skew_d = '0;
    else if ((state_q == ST_RUN) && (skew_now > skew_q)) skew_d = skew_now;
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) skew_q <= '0;
    else        skew_q <= skew_d;
  end

  assign skew_max = skew_q;
`else
  logic unused_skew;
  assign unused_skew = ^{fifo1_count, fifo2_count, start_acc};
  assign skew_max    = '0;
`endif

endmodule
